// File: rtl/sdram_sched_pkg.sv
// Shared FSM encoding and helpers for the SDRAM burst scheduler.
package sdram_sched_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [1:0] UPDT = 2'd3;

  // Widest address the advance helper handles; callers zero-extend ASIZE-bit values.
  localparam int ADDR_MAX_W = 32;
  typedef logic [ADDR_MAX_W-1:0] addr_t;

  typedef struct packed {
    logic  wrap;
    addr_t addr;
  } adv_t;

  function automatic int ch_id_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Step to the next burst only if that whole burst still ends at or below max; else wrap to base.
  function automatic adv_t addr_advance(input addr_t addr, input addr_t base,
                                        input addr_t max_addr, input addr_t len);
    logic [ADDR_MAX_W:0] next_end;
    adv_t                r;
    // NOTE: blocking '=' is right for function/combinational temporaries; they are not state.
    next_end = {1'b0, addr} + {1'b0, len} + {1'b0, len};
    if (next_end <= {1'b0, max_addr}) begin
      r.wrap = 1'b0;
      r.addr = addr + len;
    end else begin
      r.wrap = 1'b1;
      r.addr = base;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdram_rr_picker.sv
// Combinational channel picker: rotating round-robin from ptr+1, or fixed priority (reads, then low index).
module sdram_rr_picker #(
  parameter int                NUM_CH   = 4,
  parameter logic [NUM_CH-1:0] CH_IS_RD = '0,
  parameter int                CH_ID_W  = 2
) (
  input  logic [NUM_CH-1:0]  req,
  input  logic [CH_ID_W-1:0] ptr,
  input  logic               mode,
  output logic               valid,
  output logic [CH_ID_W-1:0] index
);

  always_comb begin
    // NOTE: outputs get defaults before any branch so no path leaves them unassigned (no latch).
    valid = 1'b0;
    index = '0;
    if (mode) begin
      // Downward scans: the last hit is the lowest index, and the read scan overrides the write scan.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (req[i] && !CH_IS_RD[i]) begin
          valid = 1'b1;
          index = CH_ID_W'(i);
        end
      end
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (req[i] && CH_IS_RD[i]) begin
          valid = 1'b1;
          index = CH_ID_W'(i);
        end
      end
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        if (req[(int'(ptr) + k) % NUM_CH]) begin
          valid = 1'b1;
          index = CH_ID_W'((int'(ptr) + k) % NUM_CH);
        end
      end
    end
  end

endmodule

// File: rtl/sdram_burst_sched.sv
// N-channel SDRAM burst scheduler: arbitrates channel FIFOs, issues one burst at a time,
// and advances each channel's ring address after its burst completes.
module sdram_burst_sched
  import sdram_sched_pkg::*;
#(
  parameter int                NUM_CH     = 4,
  parameter logic [NUM_CH-1:0] CH_IS_RD   = 4'b0011,
  parameter int                ASIZE      = 22,
  parameter int                LEN_W      = 9,
  parameter int                LVL_W      = 16,
  parameter int                FIFO_DEPTH = 512,
  parameter int                PRIO_MODE  = 0
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_CH-1:0]         CH_EN,
  input  logic [NUM_CH-1:0]         CH_LOAD,
  input  logic [NUM_CH*ASIZE-1:0]   CH_BASE_ADDR,
  input  logic [NUM_CH*ASIZE-1:0]   CH_MAX_ADDR,
  input  logic [NUM_CH*LEN_W-1:0]   CH_LENGTH,
  input  logic [NUM_CH*LVL_W-1:0]   CH_LEVEL,
  output logic                      BURST_REQ,
  output logic                      BURST_WR,
  output logic [ASIZE-1:0]          BURST_ADDR,
  output logic [LEN_W-1:0]          BURST_LEN,
  output logic [$clog2(NUM_CH)-1:0] BURST_CH,
  input  logic                      BURST_ACK,
  input  logic                      BURST_DONE,
  output logic [NUM_CH-1:0]         CH_GRANT,
  output logic [NUM_CH-1:0]         CH_WRAP,
  output logic                      PROTO_ERR
);

  localparam int CH_ID_W = ch_id_w(NUM_CH);
  typedef logic [LVL_W:0] lvl_ext_t;

  logic [1:0]         state;
  logic [ASIZE-1:0]   ch_addr [NUM_CH];
  logic [LEN_W-1:0]   ch_len  [NUM_CH];
  logic [CH_ID_W-1:0] rr_ptr;
  logic               load_hit;
  logic [NUM_CH-1:0]  elig;
  logic               pick_valid;
  logic [CH_ID_W-1:0] pick_idx;
  adv_t               adv;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_elig
    lvl_ext_t level, free_words, need;
    assign level      = {1'b0, CH_LEVEL[g*LVL_W +: LVL_W]};
    assign free_words = lvl_ext_t'(FIFO_DEPTH) - level;
    assign need       = lvl_ext_t'(ch_len[g]);
    // A borrow in free_words means the read FIFO reports more than full: treat as no room.
    assign elig[g] = CH_EN[g] && !CH_LOAD[g] && (ch_len[g] != '0) &&
                     (CH_IS_RD[g] ? (!free_words[LVL_W] && (free_words >= need))
                                  : (level >= need));
  end

  sdram_rr_picker #(
    .NUM_CH   (NUM_CH),
    .CH_IS_RD (CH_IS_RD),
    .CH_ID_W  (CH_ID_W)
  ) u_picker (
    .req   (elig),
    .ptr   (rr_ptr),
    .mode  (PRIO_MODE != 0),
    .valid (pick_valid),
    .index (pick_idx)
  );

  assign adv = addr_advance(addr_t'(ch_addr[BURST_CH]),
                            addr_t'(CH_BASE_ADDR[BURST_CH*ASIZE +: ASIZE]),
                            addr_t'(CH_MAX_ADDR[BURST_CH*ASIZE +: ASIZE]),
                            addr_t'(ch_len[BURST_CH]));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      BURST_REQ  <= 1'b0;
      BURST_WR   <= 1'b0;
      BURST_ADDR <= '0;
      BURST_LEN  <= '0;
      BURST_CH   <= '0;
      CH_GRANT   <= '0;
      CH_WRAP    <= '0;
      PROTO_ERR  <= 1'b0;
      rr_ptr     <= CH_ID_W'(NUM_CH - 1);
      load_hit   <= 1'b0;
      // NOTE: the per-channel arrays are real state that arbitration reads, so they are reset too.
      for (int i = 0; i < NUM_CH; i++) begin
        ch_addr[i] <= CH_BASE_ADDR[i*ASIZE +: ASIZE];
        ch_len[i]  <= CH_LENGTH[i*LEN_W +: LEN_W];
      end
    end else begin
      CH_WRAP <= '0;
      if (BURST_DONE && (state != XFER)) PROTO_ERR <= 1'b1;

      for (int i = 0; i < NUM_CH; i++) begin
        if (CH_LOAD[i]) begin
          ch_addr[i] <= CH_BASE_ADDR[i*ASIZE +: ASIZE];
          ch_len[i]  <= CH_LENGTH[i*LEN_W +: LEN_W];
        end
      end
      // Remember a reload of the granted channel so its post-burst advance is skipped.
      if ((state != IDLE) && CH_LOAD[BURST_CH]) load_hit <= 1'b1;

      case (state)
        IDLE: begin
          if (pick_valid) begin
            state      <= REQ;
            BURST_CH   <= pick_idx;
            BURST_WR   <= !CH_IS_RD[pick_idx];
            BURST_ADDR <= ch_addr[pick_idx];
            BURST_LEN  <= ch_len[pick_idx];
            CH_GRANT   <= {{(NUM_CH-1){1'b0}}, 1'b1} << pick_idx;
            load_hit   <= 1'b0;
            if (PRIO_MODE == 0) rr_ptr <= pick_idx;
          end
        end
        REQ: begin
          if (BURST_REQ && BURST_ACK) begin
            BURST_REQ <= 1'b0;
            state     <= XFER;
          end else begin
            BURST_REQ <= 1'b1;
          end
        end
        XFER: begin
          if (BURST_DONE) state <= UPDT;
        end
        UPDT: begin
          CH_GRANT <= '0;
          state    <= IDLE;
          if (!load_hit && !CH_LOAD[BURST_CH]) begin
            ch_addr[BURST_CH] <= adv.addr[ASIZE-1:0];
            CH_WRAP[BURST_CH] <= adv.wrap;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Self-checking bench: one round-robin and one fixed-priority scheduler driven against a channel-level model.
module tb_sdram_burst_sched;

  localparam int                NUM_CH     = 4;
  localparam int                ASIZE      = 22;
  localparam int                LEN_W      = 9;
  localparam int                LVL_W      = 16;
  localparam int                FIFO_DEPTH = 512;
  localparam logic [NUM_CH-1:0] RD_MASK    = 4'b0011;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]       ch_en     [2];
  logic [NUM_CH-1:0]       ch_load   [2];
  logic [NUM_CH*ASIZE-1:0] ch_base   [2];
  logic [NUM_CH*ASIZE-1:0] ch_max    [2];
  logic [NUM_CH*LEN_W-1:0] ch_length [2];
  logic [NUM_CH*LVL_W-1:0] ch_level  [2];
  logic                    burst_req [2];
  logic                    burst_wr  [2];
  logic [ASIZE-1:0]        burst_addr[2];
  logic [LEN_W-1:0]        burst_len [2];
  logic [1:0]              burst_ch  [2];
  logic                    burst_ack [2];
  logic                    burst_done[2];
  logic [NUM_CH-1:0]       ch_grant  [2];
  logic [NUM_CH-1:0]       ch_wrap   [2];
  logic                    proto_err [2];

  sdram_burst_sched #(
    .NUM_CH(NUM_CH), .CH_IS_RD(RD_MASK), .ASIZE(ASIZE), .LEN_W(LEN_W),
    .LVL_W(LVL_W), .FIFO_DEPTH(FIFO_DEPTH), .PRIO_MODE(0)
  ) u_rr (
    .CLK(clk), .RESET(reset), .CH_EN(ch_en[0]), .CH_LOAD(ch_load[0]),
    .CH_BASE_ADDR(ch_base[0]), .CH_MAX_ADDR(ch_max[0]), .CH_LENGTH(ch_length[0]),
    .CH_LEVEL(ch_level[0]), .BURST_REQ(burst_req[0]), .BURST_WR(burst_wr[0]),
    .BURST_ADDR(burst_addr[0]), .BURST_LEN(burst_len[0]), .BURST_CH(burst_ch[0]),
    .BURST_ACK(burst_ack[0]), .BURST_DONE(burst_done[0]), .CH_GRANT(ch_grant[0]),
    .CH_WRAP(ch_wrap[0]), .PROTO_ERR(proto_err[0])
  );

  sdram_burst_sched #(
    .NUM_CH(NUM_CH), .CH_IS_RD(RD_MASK), .ASIZE(ASIZE), .LEN_W(LEN_W),
    .LVL_W(LVL_W), .FIFO_DEPTH(FIFO_DEPTH), .PRIO_MODE(1)
  ) u_prio (
    .CLK(clk), .RESET(reset), .CH_EN(ch_en[1]), .CH_LOAD(ch_load[1]),
    .CH_BASE_ADDR(ch_base[1]), .CH_MAX_ADDR(ch_max[1]), .CH_LENGTH(ch_length[1]),
    .CH_LEVEL(ch_level[1]), .BURST_REQ(burst_req[1]), .BURST_WR(burst_wr[1]),
    .BURST_ADDR(burst_addr[1]), .BURST_LEN(burst_len[1]), .BURST_CH(burst_ch[1]),
    .BURST_ACK(burst_ack[1]), .BURST_DONE(burst_done[1]), .CH_GRANT(ch_grant[1]),
    .CH_WRAP(ch_wrap[1]), .PROTO_ERR(proto_err[1])
  );

  int checks = 0;
  int errors = 0;

  // Channel-level reference model; [0] = round-robin instance, [1] = priority instance.
  int m_base [2][NUM_CH];
  int m_max  [2][NUM_CH];
  int m_len  [2][NUM_CH];
  int m_addr [2][NUM_CH];
  int m_level[2][NUM_CH];
  bit m_en   [2][NUM_CH];
  int m_ptr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k);
    for (int c = 0; c < NUM_CH; c++) begin
      ch_en[k][c]                    = m_en[k][c];
      ch_base[k][c*ASIZE +: ASIZE]   = ASIZE'(m_base[k][c]);
      ch_max[k][c*ASIZE +: ASIZE]    = ASIZE'(m_max[k][c]);
      ch_length[k][c*LEN_W +: LEN_W] = LEN_W'(m_len[k][c]);
      ch_level[k][c*LVL_W +: LVL_W]  = LVL_W'(m_level[k][c]);
    end
  endtask

  function automatic bit eligible(input int k, input int c);
    if (!m_en[k][c] || m_len[k][c] == 0) return 1'b0;
    if (RD_MASK[c]) return (FIFO_DEPTH - m_level[k][c]) >= m_len[k][c];
    return m_level[k][c] >= m_len[k][c];
  endfunction

  function automatic int predict(input int k);
    if (k == 0) begin
      for (int s = 1; s <= NUM_CH; s++)
        if (eligible(0, (m_ptr + s) % NUM_CH)) return (m_ptr + s) % NUM_CH;
    end else begin
      for (int c = 0; c < NUM_CH; c++) if (RD_MASK[c] && eligible(1, c)) return c;
      for (int c = 0; c < NUM_CH; c++) if (!RD_MASK[c] && eligible(1, c)) return c;
    end
    return -1;
  endfunction

  task automatic wait_req(input int k);
    int n = 0;
    while (burst_req[k] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", burst_req[k], 1);
  endtask

  // One full burst: predict winner, handshake, optionally reload a channel mid-burst, check the update.
  task automatic do_burst(input int k, input int load_ch, input int new_base);
    int          w;
    logic [63:0] wrap_exp;
    w = predict(k);
    if (w < 0) begin
      repeat (4) tick();
      check("quiet", burst_req[k], 0);
      return;
    end
    wait_req(k);
    check("burst_ch", burst_ch[k], w);
    check("burst_wr", burst_wr[k], !RD_MASK[w]);
    check("burst_addr", burst_addr[k], m_addr[k][w]);
    check("burst_len", burst_len[k], m_len[k][w]);
    check("grant", ch_grant[k], 64'd1 << w);
    burst_ack[k] = 1'b1;
    tick();
    burst_ack[k] = 1'b0;
    check("req_drop", burst_req[k], 0);
    if (load_ch >= 0) begin
      m_base[k][load_ch] = new_base;
      m_addr[k][load_ch] = new_base;
      drive(k);
      ch_load[k][load_ch] = 1'b1;
      tick();
      ch_load[k][load_ch] = 1'b0;
    end
    repeat ($urandom_range(0, 8)) tick();
    burst_done[k] = 1'b1;
    tick();
    burst_done[k] = 1'b0;
    check("grant_hold", ch_grant[k], 64'd1 << w);
    check("wrap_pre", ch_wrap[k], 0);
    tick();
    wrap_exp = '0;
    if (load_ch != w) begin
      if (m_addr[k][w] + 2 * m_len[k][w] <= m_max[k][w]) m_addr[k][w] += m_len[k][w];
      else begin
        m_addr[k][w] = m_base[k][w];
        wrap_exp     = 64'd1 << w;
      end
    end
    check("wrap", ch_wrap[k], wrap_exp);
    check("grant_clr", ch_grant[k], 0);
    if (k == 0) m_ptr = w;
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ch_load[k]    = '0;
      burst_ack[k]  = 1'b0;
      burst_done[k] = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_base[k][c]  = (k == 0) ? c * 'h1000 : c * 'h800;
        m_max[k][c]   = m_base[k][c] + ((k == 0) ? 32 : 'h400);
        m_len[k][c]   = 8;
        m_addr[k][c]  = m_base[k][c];
        m_en[k][c]    = (k == 0);
        m_level[k][c] = RD_MASK[c] ? 0 : 100;
      end
      drive(k);
    end
    m_ptr = NUM_CH - 1;
    tick();
    tick();
    reset = 1'b0;

    check("rst_req", burst_req[0], 0);
    check("rst_wr", burst_wr[0], 0);
    check("rst_addr", burst_addr[0], 0);
    check("rst_len", burst_len[0], 0);
    check("rst_ch", burst_ch[0], 0);
    check("rst_grant", ch_grant[0], 0);
    check("rst_wrap", ch_wrap[0], 0);
    check("rst_perr", proto_err[0], 0);
    check("rst_prio_req", burst_req[1], 0);

    // All channels eligible: rotation 0,1,2,3 and each ring wraps after four bursts.
    for (int i = 0; i < 17; i++) do_burst(0, -1, 0);

    for (int i = 0; i < 24; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_en[0][c]    = ($urandom_range(0, 3) != 0);
        m_level[0][c] = RD_MASK[c] ? int'($urandom_range(496, 512)) : int'($urandom_range(0, 12));
      end
      drive(0);
      do_burst(0, -1, 0);
    end

    // Reload channel 0 mid-burst: no advance, no wrap, next burst starts at the new base.
    for (int c = 0; c < NUM_CH; c++) m_en[0][c] = (c == 0);
    m_level[0][0] = 0;
    m_max[0][0]   = 'h200;
    drive(0);
    do_burst(0, 0, 'h100);
    do_burst(0, -1, 0);

    // Write-channel threshold and two-cycle request latency.
    for (int c = 0; c < NUM_CH; c++) m_en[0][c] = (c == 2);
    m_level[0][2] = 7;
    drive(0);
    repeat (5) tick();
    check("lvl7_no_req", burst_req[0], 0);
    m_level[0][2] = 8;
    drive(0);
    tick();
    check("lvl8_decide", burst_req[0], 0);
    tick();
    check("lvl8_req", burst_req[0], 1);
    do_burst(0, -1, 0);

    // Reset in XFER, then a stray DONE in IDLE.
    for (int c = 0; c < NUM_CH; c++) begin
      m_en[0][c]    = 1'b1;
      m_level[0][c] = RD_MASK[c] ? 0 : 100;
    end
    drive(0);
    wait_req(0);
    burst_ack[0] = 1'b1;
    tick();
    burst_ack[0] = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("xrst_req", burst_req[0], 0);
    check("xrst_grant", ch_grant[0], 0);
    check("xrst_perr", proto_err[0], 0);
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NUM_CH; c++) m_addr[k][c] = m_base[k][c];
    m_ptr = NUM_CH - 1;
    burst_done[0] = 1'b1;
    tick();
    burst_done[0] = 1'b0;
    check("perr_set", proto_err[0], 1);
    do_burst(0, -1, 0);
    check("perr_sticky", proto_err[0], 1);

    // Fixed priority: read channel 1 wins unless its FIFO is full.
    for (int c = 0; c < NUM_CH; c++) m_en[1][c] = (c != 0);
    for (int i = 0; i < 12; i++) begin
      m_level[1][1] = ($urandom_range(0, 2) == 0) ? FIFO_DEPTH : int'($urandom_range(0, 504));
      m_level[1][2] = $urandom_range(0, 12);
      m_level[1][3] = $urandom_range(0, 12);
      drive(1);
      do_burst(1, -1, 0);
    end
    check("prio_perr", proto_err[1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
